// File: rtl/imem_responder_if.sv
// Fetch-side bus between the PC/fetch stage (master) and the instruction
// memory responder (slave).
//   req_valid/req_ready/req_addr : fetch request handshake, byte address
//   flush                        : PC redirect, drop buffered responses
//   rsp_valid/rsp_ready          : response handshake
//   rsp_addr/rsp_data            : echoed address and instruction word
//   rsp_misaligned/out_of_range  : fault flags of the response
interface imem_responder_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            flush;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_addr;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_misaligned;
  logic            rsp_out_of_range;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_misaligned, rsp_out_of_range
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_misaligned, rsp_out_of_range
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder. Word-addressed store mapped at BASE_ADDR,
// read at the accepting edge straight into a 2-entry in-order response
// buffer, so a response appears one cycle after acceptance.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   bus (slave)      : fetch request / response handshake plus flush
//   load_we/addr/data: loader write port (word index), read-first vs fetch
module imem_responder #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] BASE_ADDR   = 'h8000,
  parameter int unsigned     DEPTH_WORDS = 1024,
  localparam int unsigned    AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                reset_n,
  imem_responder_if.slave     bus,
  input  logic                load_we,
  input  logic [AW-1:0]       load_addr,
  input  logic [XLEN-1:0]     load_data
);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            mis;
    logic            oor;
  } entry_t;

  // Range bounds held one bit wider so BASE + 4*DEPTH cannot wrap.
  localparam logic [XLEN:0] LO = {1'b0, BASE_ADDR};
  localparam logic [XLEN:0] HI = LO + ((XLEN+1)'(DEPTH_WORDS) << 2);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  entry_t          ent_q [2];
  entry_t          ent_d [2];
  logic [1:0]      count_q, count_d;

  entry_t          new_ent;
  logic [XLEN-1:0] offset;
  logic [XLEN:0]   addr_ext;
  logic [AW-1:0]   rd_idx;
  logic            push, pop, req_ready;

  // Loader port; the store is deliberately not reset. Because the fetch
  // read below samples mem before this nonblocking write lands, a fetch
  // of the same word at the same edge sees the old contents.
  always_ff @(posedge clk) begin
    if (reset_n && load_we) mem[load_addr] <= load_data;
  end

  always_comb begin
    offset       = bus.req_addr - BASE_ADDR;
    addr_ext     = {1'b0, bus.req_addr};
    rd_idx       = AW'(offset >> 2);
    new_ent.addr = bus.req_addr;
    new_ent.mis  = |bus.req_addr[1:0];
    new_ent.oor  = (addr_ext < LO) || (addr_ext >= HI);
    new_ent.data = (new_ent.mis || new_ent.oor) ? '0 : mem[rd_idx];
  end

  always_comb begin
    pop       = (count_q != 2'd0) && bus.rsp_ready && !bus.flush;
    req_ready = reset_n && !bus.flush && ((count_q < 2'd2) || pop);
    push      = bus.req_valid && req_ready;
  end

  // Head is always ent[0]; a pop shifts ent[1] down.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (bus.flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          ent_d[count_q[0]] = new_ent;
          count_d           = count_q + 2'd1;
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent_d[0] = new_ent;
          end else begin
            ent_d[0] = ent_q[1];
            ent_d[1] = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  assign bus.req_ready        = req_ready;
  assign bus.rsp_valid        = (count_q != 2'd0);
  assign bus.rsp_addr         = ent_q[0].addr;
  assign bus.rsp_data         = ent_q[0].data;
  assign bus.rsp_misaligned   = ent_q[0].mis;
  assign bus.rsp_out_of_range = ent_q[0].oor;

endmodule
